alu_cmd_sequencer: RTL

Sequential command front-end for the team's 8-bit combinational ALU (add, sub, xor, left-shift). It accepts operand/opcode commands over a valid/ready handshake and drives registered operands into the ALU. It then captures the selected result and flag into a response register offered downstream over a second valid/ready handshake. Optional accumulator chaining lets a command use the previous result as operand A.

---
 rtl/alu_seq_pkg.sv | 9 +
 rtl/alu_result_mux.sv | 21 ++
 rtl/alu_cmd_sequencer.sv | 82 ++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared width, opcodes and FSM encoding for alu_cmd_sequencer
package alu_seq_pkg;
  localparam int DW = 8;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_SHL = 2'd3;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_result_mux.sv
// alu_result_mux: selects ALU result/flag by opcode and flags a zero result
module alu_result_mux
  import alu_seq_pkg::*;
(
  input  logic [1:0]    op,
  input  logic [DW-1:0] sum,
  input  logic [DW-1:0] diff,
  input  logic [DW-1:0] xr,
  input  logic [DW-1:0] shl,
  input  logic          cout,
  input  logic          bout,
  output logic [DW-1:0] result,
  output logic          flag,
  output logic          zero
);
  always_comb begin
    result = op == OP_SHL ? shl : op == OP_XOR ? xr : op == OP_SUB ? diff : sum;
    flag   = op == OP_ADD ? cout : op == OP_SUB ? bout : 1'b0;
    zero   = result == '0;
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command front-end for the 8-bit ALU.
// Define ACC_CHAIN_EN to build the accumulator used by cmd_chain.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic          cmd_chain,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op,
  input  logic [DW-1:0] alu_sum,
  input  logic [DW-1:0] alu_diff,
  input  logic [DW-1:0] alu_xor,
  input  logic [DW-1:0] alu_shl,
  input  logic          alu_cout,
  input  logic          alu_bout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_flag,
  output logic          rsp_zero,
  output logic [15:0]   rsp_cnt
);
  state_t state, state_n;
  logic [DW-1:0] mux_result, op_a;
  logic mux_flag, mux_zero, cmd_fire, rsp_fire;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  alu_result_mux u_mux (
    .op(alu_op), .sum(alu_sum), .diff(alu_diff), .xr(alu_xor), .shl(alu_shl),
    .cout(alu_cout), .bout(alu_bout), .result(mux_result), .flag(mux_flag), .zero(mux_zero)
  );
`ifdef ACC_CHAIN_EN
  logic [DW-1:0] acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (state == EXEC) acc <= mux_result;
  assign op_a = cmd_chain ? acc : cmd_a;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain;
  assign op_a = cmd_a;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (cmd_fire ? EXEC : IDLE) :
              state == EXEC ? RESP : (rsp_fire ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_flag   <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_cnt    <= '0;
    end else begin
      if (cmd_fire) begin
        alu_a  <= op_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
      end
      if (state == EXEC) begin
        rsp_result <= mux_result;
        rsp_flag   <= mux_flag;
        rsp_zero   <= mux_zero;
      end
      if (rsp_fire) rsp_cnt <= rsp_cnt + 16'd1;
    end
endmodule
